// File: rtl/mult_sequencer.sv
// Control sequencer for an N-bit shift-add signed multiplier: clear X, then N add/sub + shift steps.
// Optional macro MULT_SEQ_SKIP_ADD_EN folds the shift into the ADD cycle when M=0.
module mult_sequencer #(
  parameter int N = 8
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Execute,
  input  logic ClearXA_LoadB,
  input  logic M,
  output logic Clr_XA,
  output logic Ld_B,
  output logic Add,
  output logic Sub,
  output logic Shift,
  output logic Busy,
  output logic Done
);

  localparam int KW = $clog2(N);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLRX,
    ADD,
    SHIFT,
    HOLD
  } state_t;

  state_t        state;
  logic [KW-1:0] k;
  logic          k_last;

  assign k_last = (k == K_LAST);

  // NOTE: state and counter are flops, so they use non-blocking assignments only;
  // blocking here would let later statements see the new value within the same edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Execute) state <= CLRX;
        end
        CLRX: begin
          k     <= '0;
          state <= ADD;
        end
        ADD: begin
`ifdef MULT_SEQ_SKIP_ADD_EN
          if (M) begin
            state <= SHIFT;
          end else if (k_last) begin
            state <= HOLD;
          end else begin
            k <= k + 1'b1;
          end
`else
          state <= SHIFT;
`endif
        end
        SHIFT: begin
          if (k_last) begin
            state <= HOLD;
          end else begin
            k     <= k + 1'b1;
            state <= ADD;
          end
        end
        HOLD: begin
          if (!Execute) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    Clr_XA = 1'b0;
    Ld_B   = 1'b0;
    Add    = 1'b0;
    Sub    = 1'b0;
    Shift  = 1'b0;
    Busy   = 1'b0;
    Done   = 1'b0;
    case (state)
      IDLE: begin
        // Execute has priority; Reset_n gating keeps loads quiet while held in reset.
        Clr_XA = ClearXA_LoadB & ~Execute & Reset_n;
        Ld_B   = ClearXA_LoadB & ~Execute & Reset_n;
      end
      CLRX: begin
        Clr_XA = 1'b1;
        Busy   = 1'b1;
      end
      ADD: begin
        Busy = 1'b1;
        Add  = M & ~k_last;
        // The final partial product carries the sign weight, hence subtract.
        Sub  = M & k_last;
`ifdef MULT_SEQ_SKIP_ADD_EN
        Shift = ~M;
`endif
      end
      SHIFT: begin
        Busy  = 1'b1;
        Shift = 1'b1;
      end
      HOLD: begin
        Done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer with a behavioural B register feeding M.
// Expected run profiles are pushed by the driver and checked by a monitor when Done rises.
module tb_mult_sequencer;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic Execute = 1'b0;
  logic ClearXA_LoadB = 1'b0;
  logic M;
  logic Clr_XA, Ld_B, Add, Sub, Shift, Busy, Done;

  logic [7:0] sw = 8'h00;
  logic [7:0] b_reg = 8'h00;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    int busy;
    int adds;
    int subs;
    int shifts;
    int add_mask;
    int sub_mask;
  } exp_t;

  exp_t sb_q[$];

  mult_sequencer #(.N(8)) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .Execute       (Execute),
    .ClearXA_LoadB (ClearXA_LoadB),
    .M             (M),
    .Clr_XA        (Clr_XA),
    .Ld_B          (Ld_B),
    .Add           (Add),
    .Sub           (Sub),
    .Shift         (Shift),
    .Busy          (Busy),
    .Done          (Done)
  );

  always #5 Clk = ~Clk;

  // B register of the datapath; only bit 0 matters to the sequencer.
  always @(posedge Clk) begin
    if (Ld_B) b_reg <= sw;
    else if (Shift) b_reg <= b_reg >> 1;
  end
  assign M = b_reg[0];

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic exp_t mk(input int busy_fixed, input int busy_skip, input int adds,
                              input int subs, input int amask, input int smask);
    exp_t e;
`ifdef MULT_SEQ_SKIP_ADD_EN
    e.busy = busy_skip;
`else
    e.busy = busy_fixed;
`endif
    e.adds     = adds;
    e.subs     = subs;
    e.shifts   = 8;
    e.add_mask = amask;
    e.sub_mask = smask;
    return e;
  endfunction

  // Monitor: accumulates the run profile while Busy, compares on the Done rising edge.
  int runs_seen = 0;
  initial begin
    int m_busy, m_add, m_sub, m_shift, m_clr, m_ld, m_amask, m_smask, m_step, m_viol;
    logic done_q;
    exp_t e;
    m_busy = 0; m_add = 0; m_sub = 0; m_shift = 0; m_clr = 0; m_ld = 0;
    m_amask = 0; m_smask = 0; m_step = 0; m_viol = 0; done_q = 1'b0;
    forever begin
      @(negedge Clk);
      if (!Reset_n) begin
        done_q = 1'b0;
      end else begin
        if (Busy && Clr_XA) begin
          m_busy = 0; m_add = 0; m_sub = 0; m_shift = 0; m_clr = 0; m_ld = 0;
          m_amask = 0; m_smask = 0; m_step = 0; m_viol = 0;
        end
        if ($countones({Clr_XA, Ld_B, Add, Sub, Shift}) > 1) m_viol++;
        if (Busy) begin
          m_busy++;
          if (Clr_XA) m_clr++;
          if (Ld_B) m_ld++;
          if (Add) begin m_add++; m_amask |= (1 << m_step); end
          if (Sub) begin m_sub++; m_smask |= (1 << m_step); end
          if (Shift) begin m_shift++; m_step++; end
        end
        if (Done && !done_q) begin
          runs_seen++;
          if (sb_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("busy_cycles", m_busy, e.busy);
            check("add_count", m_add, e.adds);
            check("sub_count", m_sub, e.subs);
            check("shift_count", m_shift, e.shifts);
            check("add_steps", m_amask, e.add_mask);
            check("sub_steps", m_smask, e.sub_mask);
            check("clrx_pulses", m_clr, 1);
            check("ldb_while_busy", m_ld, 0);
            check("exclusive_viol", m_viol, 0);
          end
        end
        done_q = Done;
      end
    end
  end

  task automatic load_b(input logic [7:0] val);
    sw = val;
    ClearXA_LoadB = 1'b1;
    #1;
    check("idle_clr_ld", int'({Clr_XA, Ld_B}), 3);
    tick();
    ClearXA_LoadB = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && !Done; i++) tick();
    check("done_reached", int'(Done), 1);
  endtask

  task automatic do_run(input logic [7:0] bval, input exp_t e, input bit hold_clr);
    load_b(bval);
    sb_q.push_back(e);
    Execute = 1'b1;
    ClearXA_LoadB = hold_clr;
    #1;
    if (hold_clr) check("execute_wins", int'({Clr_XA, Ld_B}), 0);
    tick();
    Execute = 1'b0;
    wait_done();
    if (hold_clr) check("hold_ignores_clr", int'({Clr_XA, Ld_B}), 0);
    ClearXA_LoadB = 1'b0;
    tick();
    check("back_to_idle", int'({Busy, Done}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev_runs;
    #12;
    check("reset_outputs", int'({Clr_XA, Ld_B, Add, Sub, Shift, Busy, Done}), 0);
    tick();
    Reset_n = 1'b1;
    tick();
    check("idle_after_reset", int'({Clr_XA, Ld_B, Add, Sub, Shift, Busy, Done}), 0);

    do_run(8'h07, mk(17, 12, 3, 0, 8'h07, 8'h00), 1'b0);
    do_run(8'h80, mk(17, 10, 0, 1, 8'h00, 8'h80), 1'b0);
    do_run(8'h00, mk(17,  9, 0, 0, 8'h00, 8'h00), 1'b0);
    do_run(8'hFF, mk(17, 17, 7, 1, 8'h7F, 8'h80), 1'b0);
    do_run(8'h55, mk(17, 13, 4, 0, 8'h55, 8'h00), 1'b1);

    // Reset in the middle of a run; no expectation pushed for the aborted run.
    load_b(8'h07);
    Execute = 1'b1;
    tick();
    Execute = 1'b0;
    repeat (4) tick();
    #2;
    Reset_n = 1'b0;
    #1;
    check("midrun_reset_outputs", int'({Clr_XA, Ld_B, Add, Sub, Shift, Busy, Done}), 0);
    tick();
    Reset_n = 1'b1;
    tick();
    do_run(8'h07, mk(17, 12, 3, 0, 8'h07, 8'h00), 1'b0);

    // Execute held long: one run only, Done held, release returns to idle.
    load_b(8'h07);
    prev_runs = runs_seen;
    sb_q.push_back(mk(17, 12, 3, 0, 8'h07, 8'h00));
    Execute = 1'b1;
    tick();
    wait_done();
    repeat (50) tick();
    check("done_held", int'(Done), 1);
    check("busy_while_held", int'(Busy), 0);
    check("single_run", runs_seen - prev_runs, 1);
    Execute = 1'b0;
    tick();
    check("release_idle", int'({Busy, Done}), 0);
    do_run(8'h80, mk(17, 10, 0, 1, 8'h00, 8'h80), 1'b0);

    repeat (2) tick();
    check("queue_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Cycle-level sequencer for the N-bit shift-add signed multiplier datapath (X flip-flop, A/B shift registers, N+1-bit add/sub adder). It turns a synchronized Execute button into a fixed sequence: clear X, then N add-or-subtract/shift steps gated by the multiplier LSB M. It then holds the result until Execute is released. It also gates ClearXA_LoadB so register loads happen only while idle.

## Interface
- N, 8, multiplier width; number of add/shift steps per run (N >= 2)
- Clk  in  1  system clock, all state changes on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Execute  in  1  synchronized, active-high run request (level)
- ClearXA_LoadB  in  1  synchronized, active-high load/clear request (level)
- M  in  1  current B[0] from the datapath
- Clr_XA  out  1  clear X and A registers
- Ld_B  out  1  load B from switches
- Add  out  1  load A/X with A+S this cycle
- Sub  out  1  load A/X with A-S this cycle
- Shift  out  1  arithmetic right shift X:A:B this cycle
- Busy  out  1  run in progress
- Done  out  1  result valid, waiting for Execute release

## Operation
- One clock and one reset. Reset is asynchronous and active-low. Clock and reset ports are Clk and Reset_n.
- Reset state: IDLE, step counter k=0, all outputs 0.
- States: IDLE, CLRX, ADD, SHIFT, HOLD. Step counter k has width $clog2(N) and counts 0..N-1.
- IDLE:
  - Clr_XA = Ld_B = ClearXA_LoadB. The datapath decides how to route these.
  - Execute=1 -> CLRX. If Execute and ClearXA_LoadB are both 1, Execute wins: no Clr_XA/Ld_B, go to CLRX.
- CLRX: assert Clr_XA for 1 cycle, set k=0, then go to ADD.
- ADD (one cycle):
  - Add = M & (k != N-1).
  - Sub = M & (k == N-1).
  - Go to SHIFT.
- SHIFT (one cycle):
  - assert Shift.
  - If k == N-1 -> HOLD. Otherwise k <= k+1 and go to ADD.
- HOLD:
  - Done=1, all other outputs 0.
  - Execute=0 -> IDLE.
  - ClearXA_LoadB is ignored.
- Busy=1 in CLRX, ADD and SHIFT.
- Add, Sub, Shift, Clr_XA and Ld_B are mutually exclusive in every cycle.
- Execute deasserted during a run: ignored, the run completes.
- ClearXA_LoadB during Busy or HOLD: ignored, Clr_XA and Ld_B stay 0.
- Reset_n low at any time, including mid-run: immediate return to IDLE, outputs 0. A partial result in the datapath is not restored.

## Timing
- Outputs are decoded from registered state. Add and Sub additionally depend on M in the same cycle. Clr_XA and Ld_B depend on ClearXA_LoadB in the same cycle.
- M must be stable before the ADD cycle. B shifts only on Shift cycles, so M is the next multiplier bit one cycle after each Shift.
- Latency without skip: Execute seen in IDLE at cycle 0 -> CLRX at cycle 1 -> 2N step cycles -> Done first asserted at cycle 2N+2 (cycle 18 for N=8).
- After the run, one cycle with Execute=0 in HOLD returns to IDLE. Re-execute needs Execute 0 -> 1.

## Configuration
- Macro MULT_SEQ_SKIP_ADD_EN.
- Defined: the ADD state decides as follows.
  - M=0: assert Shift in the same cycle, update k exactly as SHIFT does, and stay in ADD (or go to HOLD when k == N-1).
  - M=1: behaves as without the macro.
  - Run length is 1 + N + popcount(B) cycles.
- Undefined: fixed 2N-step sequence exactly as in Operation. Run length is always 1 + 2N cycles.

## Test plan
- N=8, no macro, B=0x07, Execute pulse: Clr_XA once, then 3 Add pulses at k=0..2, 0 Sub, 8 Shift. Busy for 17 cycles, then Done until Execute=0.
- B=0x80, no macro: 0 Add, exactly 1 Sub, which occurs at k=7 immediately before the last Shift, 8 Shift.
- MULT_SEQ_SKIP_ADD_EN, B=0x07: Busy for 12 cycles, 3 Add, 8 Shift. B=0x00: Busy for 9 cycles, 0 Add/Sub.
- Reset_n low at cycle 5 of a run: all outputs 0 in the same cycle, state IDLE. A new Execute restarts from CLRX.
- ClearXA_LoadB=1 in IDLE -> Clr_XA=Ld_B=1. Held across Busy and HOLD -> Clr_XA=Ld_B=0.
- Execute held high 50 cycles: exactly one run, Done stays 1. Release -> IDLE. Press again -> second run.
